// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the pixel read-modify-write writer: mode and state
// encodings plus the helper that locates a pixel field inside a memory word.
package pixel_writer_pkg;

   localparam logic [1:0] MODE_REPLACE = 2'b00;
   localparam logic [1:0] MODE_SET     = 2'b01;
   localparam logic [1:0] MODE_CLEAR   = 2'b10;
   localparam logic [1:0] MODE_TOGGLE  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_READ_WAIT = 2'd1,
      ST_WRITE     = 2'd2
   } state_t;

   // Pixels are packed MSB-first, so slot 0 sits at the top of the word.
   function automatic int unsigned pixel_shift(input int unsigned data_width,
                                               input int unsigned bpp,
                                               input int unsigned index);
      return data_width - (index + 1) * bpp;
   endfunction

endpackage

// File: rtl/pixel_field_merge.sv
// Combinational merge of one BPP-wide pixel operand into a memory word
// using the replace / set / clear / toggle mode encodings.
module pixel_field_merge
   import pixel_writer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BPP        = 1,
   parameter int IDX_W      = 5
) (
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [IDX_W-1:0]      index_i,
   input  logic [BPP-1:0]        value_i,
   input  logic [1:0]            mode_i,
   output logic [DATA_WIDTH-1:0] word_o
);

   int unsigned           shift;
   logic [DATA_WIDTH-1:0] mask;
   logic [DATA_WIDTH-1:0] operand;

   assign shift   = pixel_shift(DATA_WIDTH, BPP, 32'(index_i));
   assign mask    = DATA_WIDTH'({BPP{1'b1}}) << shift;
   assign operand = DATA_WIDTH'(value_i) << shift;

   // The operand never reaches outside its own field, so no carries can leak.
   always_comb begin
      word_o = word_i;
      case (mode_i)
         MODE_REPLACE: word_o = (word_i & ~mask) | operand;
         MODE_SET:     word_o = word_i | operand;
         MODE_CLEAR:   word_o = word_i & ~operand;
         MODE_TOGGLE:  word_o = word_i ^ operand;
         default:      word_o = word_i;
      endcase
   end

endmodule

// File: rtl/pixel_rmw_writer.sv
// Single-pixel read-modify-write engine: read word, merge pixel field, write back.
// Optional last-word bypass cache enabled by macro PIXEL_WRITER_BYPASS_EN.
module pixel_rmw_writer
   import pixel_writer_pkg::*;
#(
   parameter int  DATA_WIDTH     = 32,
   parameter int  ADDRESS_LENGTH = 14,
   parameter int  BPP            = 1,
   parameter int  READ_LATENCY   = 1,
   localparam int IDX_W          = (DATA_WIDTH > BPP) ? $clog2(DATA_WIDTH / BPP) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      pix_valid,
   output logic                      pix_ready,
   input  logic [ADDRESS_LENGTH-1:0] word_address,
   input  logic [IDX_W-1:0]          pixel_index,
   input  logic [BPP-1:0]            pixel_value,
   input  logic [1:0]                mode,
   input  logic                      cache_invalidate,
   output logic [ADDRESS_LENGTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic                      mem_we,
   output logic                      busy,
   output logic [1:0]                dbg_state
);

   // Handshake: a request transfers on a rising edge where pix_valid and
   // pix_ready are both high; pix_ready is high only in IDLE outside reset.

   state_t                    state_q, state_d;
   logic [2:0]                wait_q, wait_d;
   logic [ADDRESS_LENGTH-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [BPP-1:0]            val_q, val_d;
   logic [1:0]                mode_q, mode_d;
   logic                      we_q, we_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;

   logic                      accept;
   logic                      bypass_hit;
   logic [DATA_WIDTH-1:0]     bypass_word;
   logic [DATA_WIDTH-1:0]     merge_word;
   logic [IDX_W-1:0]          merge_idx;
   logic [BPP-1:0]            merge_val;
   logic [1:0]                merge_mode;
   logic [DATA_WIDTH-1:0]     merged;

   assign pix_ready = (state_q == ST_IDLE) && !reset;
   assign accept    = pix_valid && pix_ready;
   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;
   assign mem_addr  = addr_q;
   assign mem_we    = we_q;
   assign mem_wdata = wdata_q;

   // In IDLE the merge serves a bypass hit straight from the request inputs.
   always_comb begin
      merge_word = mem_rdata;
      merge_idx  = idx_q;
      merge_val  = val_q;
      merge_mode = mode_q;
      if (state_q == ST_IDLE) begin
         merge_word = bypass_word;
         merge_idx  = pixel_index;
         merge_val  = pixel_value;
         merge_mode = mode;
      end
   end

   pixel_field_merge #(
      .DATA_WIDTH (DATA_WIDTH),
      .BPP        (BPP),
      .IDX_W      (IDX_W)
   ) u_merge (
      .word_i  (merge_word),
      .index_i (merge_idx),
      .value_i (merge_val),
      .mode_i  (merge_mode),
      .word_o  (merged)
   );

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      val_d   = val_q;
      mode_d  = mode_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d = word_address;
               idx_d  = pixel_index;
               val_d  = pixel_value;
               mode_d = mode;
               if (bypass_hit) begin
                  we_d    = 1'b1;
                  wdata_d = merged;
                  state_d = ST_WRITE;
               end else begin
                  wait_d  = 3'd0;
                  state_d = ST_READ_WAIT;
               end
            end
         end
         ST_READ_WAIT: begin
            if (wait_q == 3'(READ_LATENCY - 1)) begin
               we_d    = 1'b1;
               wdata_d = merged;
               state_d = ST_WRITE;
            end else begin
               wait_d = wait_q + 3'd1;
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         wait_q  <= 3'd0;
         addr_q  <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         mode_q  <= 2'b00;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         mode_q  <= mode_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef PIXEL_WRITER_BYPASS_EN
   logic                      byp_valid_q, byp_valid_d;
   logic [ADDRESS_LENGTH-1:0] byp_addr_q, byp_addr_d;
   logic [DATA_WIDTH-1:0]     byp_word_q, byp_word_d;

   // An invalidate in the acceptance cycle forces the read path.
   assign bypass_hit  = byp_valid_q && (byp_addr_q == word_address) && !cache_invalidate;
   assign bypass_word = byp_word_q;

   always_comb begin
      byp_valid_d = byp_valid_q;
      byp_addr_d  = byp_addr_q;
      byp_word_d  = byp_word_q;
      if (we_d) begin
         byp_valid_d = 1'b1;
         byp_addr_d  = addr_d;
         byp_word_d  = wdata_d;
      end
      if (cache_invalidate) begin
         byp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byp_valid_q <= 1'b0;
         byp_addr_q  <= '0;
         byp_word_q  <= '0;
      end else begin
         byp_valid_q <= byp_valid_d;
         byp_addr_q  <= byp_addr_d;
         byp_word_q  <= byp_word_d;
      end
   end
`else
   logic unused_invalidate;
   assign unused_invalidate = cache_invalidate;
   assign bypass_hit        = 1'b0;
   assign bypass_word       = '0;
`endif

endmodule

// File: tb/tb_pixel_rmw_writer.sv
// Randomized scoreboard bench for pixel_rmw_writer over four BPP/latency configurations.
// Build with PIXEL_WRITER_BYPASS_EN defined to exercise the bypass cache as well.
module tb_pixel_rmw_writer;

   localparam int DW = 32;
   localparam int AW = 14;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Reference pixel update written from the packing rule with plain arithmetic.
   function automatic logic [31:0] apply_pixel(input logic [31:0] w, input int bpp,
                                               input int idx, input int val,
                                               input logic [1:0] md);
      longint unsigned lo, f, nf, fmax, word, v;
      fmax = (64'd1 << bpp) - 64'd1;
      lo   = longint'(32 - (idx + 1) * bpp);
      word = {32'd0, w};
      v    = longint'(val) & fmax;
      f    = (word >> lo) & fmax;
      case (md)
         2'b00:   nf = v;
         2'b01:   nf = f | v;
         2'b10:   nf = f & (fmax ^ v);
         default: nf = f ^ v;
      endcase
      word = word - (f << lo) + ((nf & fmax) << lo);
      return word[31:0];
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_inst
      localparam int BPP_G = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 2 : 8;
      localparam int LAT_G = (g == 2) ? 3 : (g == 3) ? 2 : 1;
      localparam int IDX_W = $clog2(32 / BPP_G);
      localparam int NPIX  = 32 / BPP_G;
      localparam logic [31:0] D5 = (g == 0) ? 32'h0000_0000 : (g == 1) ? 32'h1234_5678 :
                                   (g == 2) ? 32'hFFFF_FFFF : 32'hAABB_CCDD;

      logic             rst = 1'b1;
      logic             pix_valid = 1'b0;
      logic             pix_ready;
      logic [AW-1:0]    word_address = '0;
      logic [IDX_W-1:0] pixel_index = '0;
      logic [BPP_G-1:0] pixel_value = '0;
      logic [1:0]       mode = 2'b00;
      logic             cache_inv = 1'b0;
      logic [AW-1:0]    mem_addr;
      logic [DW-1:0]    mem_rdata;
      logic [DW-1:0]    mem_wdata;
      logic             mem_we;
      logic             busy;
      logic [1:0]       dbg_state;
      bit               done = 1'b0;

      pixel_rmw_writer #(
         .DATA_WIDTH     (DW),
         .ADDRESS_LENGTH (AW),
         .BPP            (BPP_G),
         .READ_LATENCY   (LAT_G)
      ) dut (
         .clk              (clk),
         .reset            (rst),
         .pix_valid        (pix_valid),
         .pix_ready        (pix_ready),
         .word_address     (word_address),
         .pixel_index      (pixel_index),
         .pixel_value      (pixel_value),
         .mode             (mode),
         .cache_invalidate (cache_inv),
         .mem_addr         (mem_addr),
         .mem_rdata        (mem_rdata),
         .mem_wdata        (mem_wdata),
         .mem_we           (mem_we),
         .busy             (busy),
         .dbg_state        (dbg_state)
      );

      function automatic logic [31:0] init_word(input int a);
         if (a == 5) return D5;
         if (a == 7) return 32'h0;
         return (32'h9E37_79B9 * 32'(a + 1)) ^ 32'(g);
      endfunction

      // Memory: data is only valid LAT_G cycles after the request was accepted.
      logic [DW-1:0] mem [16];
      logic [DW-1:0] garbage = '0;
      int            acc_cyc = -100;
      always @(posedge clk) begin
         garbage <= $urandom;
         if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
         end else if (mem_we) begin
            mem[mem_addr[3:0]] <= mem_wdata;
         end
         if (pix_valid && pix_ready) acc_cyc <= cyc;
      end
      assign mem_rdata = ((cyc - acc_cyc) >= LAT_G) ? mem[mem_addr[3:0]] : garbage;

      logic [31:0] ref_mem [16];
      bit          byp_v = 1'b0;
      int          byp_a = -1;
      exp_t        exp_q[$];

      task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
         checks++;
         if (act !== req) begin
            errors++;
            $display("FAIL %s inst %0d cyc %0d: got %h expected %h", name, g, cyc, act, req);
         end
      endtask

      // Monitor: samples 2 time units after the falling edge.
      initial begin
         exp_t        e;
         logic [31:0] prev_wdata = '0;
         bit          prev_ok = 1'b0;
         int          exp_ready = -1;
         int          rst_age = 0;
         forever begin
            @(negedge clk);
            #2;
            if (rst) begin
               rst_age++;
               prev_ok   = 1'b0;
               exp_ready = -1;
               if (rst_age >= 2) begin
                  chk("rst_we", 32'(mem_we), 32'd0);
                  chk("rst_addr", 32'(mem_addr), 32'd0);
                  chk("rst_wdata", mem_wdata, 32'd0);
                  chk("rst_busy", 32'(busy), 32'd0);
                  chk("rst_ready", 32'(pix_ready), 32'd0);
               end
            end else begin
               rst_age = 0;
               chk("ready_vs_busy", 32'(pix_ready), 32'(!busy));
               if (mem_we) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_write", 32'(mem_we), 32'd0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("write_addr", 32'(mem_addr), 32'(e.addr));
                     chk("write_data", mem_wdata, e.data);
                     chk("write_cycle", 32'(cyc), 32'(e.due));
                     exp_ready = cyc + 1;
                  end
               end else if (prev_ok) begin
                  chk("wdata_hold", mem_wdata, prev_wdata);
               end
               if (cyc == exp_ready) chk("ready_after_write", 32'(pix_ready), 32'd1);
               prev_wdata = mem_wdata;
               prev_ok    = 1'b1;
            end
         end
      end

      // Drives junk requests while the writer is busy; they must be ignored.
      task automatic wait_ready();
         int n = 0;
         while (!pix_ready && n < 30) begin
            pix_valid    = 1'($urandom_range(0, 1));
            word_address = AW'($urandom);
            pixel_index  = IDX_W'($urandom);
            pixel_value  = BPP_G'($urandom);
            mode         = 2'($urandom);
`ifdef PIXEL_WRITER_BYPASS_EN
            cache_inv    = 1'b0;
`else
            cache_inv    = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
            n++;
         end
         if (!pix_ready) begin
            errors++;
            $display("FAIL ready_timeout inst %0d: got pix_ready 0 expected 1 within 30 cycles", g);
         end
      endtask

      task automatic send_req(input int a, input int idx, input int val, input logic [1:0] md,
                              input logic inv, input bit abort, input bit use_lit,
                              input logic [31:0] lit);
         exp_t        e;
         logic [31:0] nw;
         bit          hit;
         wait_ready();
         pix_valid    = 1'b1;
         word_address = AW'(a);
         pixel_index  = IDX_W'(idx);
         pixel_value  = BPP_G'(val);
         mode         = md;
         cache_inv    = inv;
`ifdef PIXEL_WRITER_BYPASS_EN
         hit = byp_v && (byp_a == a) && !inv;
`else
         hit = 1'b0;
`endif
         nw = apply_pixel(ref_mem[a], BPP_G, idx, val, md);
         if (!abort) begin
            ref_mem[a] = nw;
            e.addr = a;
            e.data = use_lit ? lit : nw;
            e.due  = cyc + (hit ? 1 : LAT_G + 1);
            exp_q.push_back(e);
            byp_v = 1'b1;
            byp_a = a;
         end else begin
            byp_v = 1'b0;
         end
         @(negedge clk);
      endtask

      task automatic idle_gap(input logic inv);
         wait_ready();
         pix_valid = 1'b0;
         cache_inv = inv;
         if (inv) byp_v = 1'b0;
         @(negedge clk);
      endtask

      task automatic do_reset(input int n);
         rst          = 1'b1;
         pix_valid    = 1'b1;
         word_address = AW'($urandom);
         cache_inv    = 1'b0;
         repeat (n) @(negedge clk);
         rst = 1'b0;
         for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
         byp_v = 1'b0;
         #1;
      endtask

      initial begin
         int n;
         @(negedge clk);
         do_reset(3);
         case (g)
            0:       send_req(5, 0, 1, 2'b01, 1'b0, 1'b0, 1'b1, 32'h8000_0000);
            1:       send_req(5, 2, 15, 2'b00, 1'b0, 1'b0, 1'b1, 32'h12F4_5678);
            2:       send_req(5, 15, 1, 2'b11, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
            default: send_req(5, 1, 15, 2'b10, 1'b0, 1'b0, 1'b1, 32'hAAB0_CCDD);
         endcase
`ifdef PIXEL_WRITER_BYPASS_EN
         if (g == 0) begin
            send_req(7, 0, 1, 2'b01, 1'b0, 1'b0, 1'b1, 32'h8000_0000);
            send_req(7, 1, 1, 2'b01, 1'b0, 1'b0, 1'b1, 32'hC000_0000);
            idle_gap(1'b1);
            send_req(7, 2, 1, 2'b01, 1'b0, 1'b0, 1'b1, 32'hE000_0000);
            send_req(7, 3, 1, 2'b01, 1'b1, 1'b0, 1'b1, 32'hF000_0000);
         end
`endif
         repeat (40) begin
            if ($urandom_range(0, 4) == 0) begin
               idle_gap(1'($urandom_range(0, 5) == 0));
            end else begin
               send_req($urandom_range(0, 7), $urandom_range(0, NPIX - 1),
                        $urandom_range(0, (1 << BPP_G) - 1), 2'($urandom),
                        1'($urandom_range(0, 5) == 0), 1'b0, 1'b0, 32'h0);
            end
         end
         // Reset while the read is outstanding: the write must never appear.
         send_req($urandom_range(0, 7), 0, 1, 2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
         do_reset(2);
         repeat (6) begin
            send_req($urandom_range(0, 7), $urandom_range(0, NPIX - 1),
                     $urandom_range(0, (1 << BPP_G) - 1), 2'($urandom),
                     1'b0, 1'b0, 1'b0, 32'h0);
         end
         pix_valid = 1'b0;
         cache_inv = 1'b0;
         n = 0;
         while (exp_q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
         end
         if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain inst %0d: got %0d pending writes expected 0", g, exp_q.size());
         end
         repeat (3) @(negedge clk);
         done = 1'b1;
      end
   end

   initial begin
      int n = 0;
      while (n < 20000 && !(g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done)) begin
         @(negedge clk);
         n++;
      end
      if (!(g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done)) begin
         errors++;
         $display("FAIL global_timeout: got unfinished drivers expected all done within 20000 cycles");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_rmw_writer.md
PIXEL_RMW_WRITER -- requirements
Module: pixel_rmw_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: memory word width in bits; power of two, at least 8.
REQ-002 SHALL have parameter ADDRESS_LENGTH, default 14: word address width.
REQ-003 SHALL have parameter BPP, default 1: bits per pixel, one of 1, 2, 4 or 8.
REQ-004 SHALL have parameter READ_LATENCY, default 1: memory read latency in cycles, 1..4.
REQ-005 SHALL have port clk  input  1: single clock; all logic on the rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-007 SHALL have port pix_valid  input  1: pixel request valid.
REQ-008 SHALL have port pix_ready  output  1: request accepted when pix_valid and pix_ready are both high.
REQ-009 SHALL have port word_address  input  ADDRESS_LENGTH: target word.
REQ-010 SHALL have port pixel_index  input  log2(DATA_WIDTH/BPP): pixel slot inside the word.
REQ-011 SHALL have port pixel_value  input  BPP: pixel operand.
REQ-012 SHALL have port mode  input  2: 00 replace, 01 OR (set), 10 AND-NOT (clear), 11 XOR (toggle).
REQ-013 SHALL have port cache_invalidate  input  1: another agent changed the memory; drop the bypass word.
REQ-014 SHALL have port mem_addr  output  ADDRESS_LENGTH: registered memory address.
REQ-015 SHALL have port mem_rdata  input  DATA_WIDTH: memory read data.
REQ-016 SHALL have port mem_wdata  output  DATA_WIDTH: registered write data.
REQ-017 SHALL have port mem_we  output  1: registered write strobe.
REQ-018 SHALL have port busy  output  1: high whenever the state is not IDLE.

Function
REQ-019 SHALL pack pixels MSB-first: pixel index i occupies bits [DATA_WIDTH-1-i*BPP -: BPP].
REQ-020 SHALL use the FSM states IDLE, READ_WAIT and WRITE.
REQ-021 SHALL assert pix_ready combinationally in IDLE only, and never while reset is high.
REQ-022 SHALL, on acceptance in cycle T, latch address, index, value and mode, and register mem_addr = word_address so that it is valid from cycle T+1.
REQ-023 SHALL hold READ_WAIT for exactly READ_LATENCY cycles and capture mem_rdata at the edge ending cycle T+READ_LATENCY.
REQ-024 SHALL drive mem_we high for exactly one cycle (T+READ_LATENCY+1), with mem_addr unchanged and mem_wdata = captured word with only the target pixel field modified per mode.
REQ-025 SHALL return to IDLE after WRITE, so pix_ready is high again at T+READ_LATENCY+2 and throughput is one pixel per READ_LATENCY+2 cycles.
REQ-026 SHALL leave every bit outside the target field unchanged; the operand is exactly BPP bits with no carry between fields.
REQ-027 SHALL ignore request inputs while not in IDLE; requests are never lost or duplicated.
REQ-028 SHALL hold mem_wdata stable when mem_we is low.

Reset
REQ-029 SHALL, while reset is high, force state to IDLE, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, and clear the bypass-valid flag.
REQ-030 SHALL, on reset asserted mid-operation, abort the operation with no mem_we pulse; it is accepted from the first cycle after reset releases.

Configuration
REQ-031 SHALL, when macro PIXEL_WRITER_BYPASS_EN is defined, keep the last written word, its address and a valid flag.
REQ-032 SHALL, with PIXEL_WRITER_BYPASS_EN defined, take an accepted request whose word_address equals the stored address with the flag valid from IDLE directly to WRITE, using the stored word with no read: mem_we at T+1, pix_ready at T+2.
REQ-033 SHALL, with PIXEL_WRITER_BYPASS_EN defined, clear the valid flag on cache_invalidate; if both occur in the same cycle, invalidate wins over a same-cycle acceptance check.
REQ-034 SHALL, without PIXEL_WRITER_BYPASS_EN, always perform the read and ignore cache_invalidate; no bypass registers exist.

Structure
REQ-035 SHALL place the mode encodings, state encodings and a pixel-shift helper function in shared package pixel_writer_pkg.
REQ-036 SHALL implement the field merge (mask, shift, mode operation) as combinational sub-module pixel_field_merge; the FSM stays in pixel_rmw_writer.

Verification (DATA_WIDTH=32, READ_LATENCY=1 unless noted)
REQ-037 SHALL cover: BPP=1, rdata 0x00000000, addr 5, idx 0, value 1, mode OR, accept at T -> mem_we only in T+2, mem_addr 5, mem_wdata 0x80000000, pix_ready back at T+3.
REQ-038 SHALL cover: BPP=4, rdata 0x12345678, idx 2, value 0xF, replace -> mem_wdata 0x12F45678.
REQ-039 SHALL cover: BPP=2, rdata 0xFFFFFFFF, idx 15, value 2'b01, XOR -> mem_wdata 0xFFFFFFFE; with READ_LATENCY=3 -> mem_we in T+4.
REQ-040 SHALL cover: BPP=8, rdata 0xAABBCCDD, idx 1, value 0x0F, AND-NOT -> mem_wdata 0xAAB0CCDD.
REQ-041 SHALL cover, with PIXEL_WRITER_BYPASS_EN: two back-to-back BPP=1 OR requests to addr 7 (idx 0, then idx 1) from rdata 0 -> second write 0xC0000000 at T2+1 with no read; repeating with cache_invalidate between -> read performed.
REQ-042 SHALL cover: reset asserted during READ_WAIT -> no mem_we pulse, all outputs 0, next request completes normally.
